riscv_decoder: RTL and testbench
================================

RISCV_DECODER -- requirements
Module: riscv_decoder

Interface
REQ-001 clk  input  1  rising-edge clock, sole clock domain.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 flush  input  1  synchronous discard of held and incoming instruction.
REQ-004 in_valid  input  1  instr/pc valid this cycle.
REQ-005 in_ready  output  1  decoder accepts instr/pc this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 out_valid  output  1  decoded bundle valid.
REQ-009 out_ready  input  1  downstream accepts bundle this cycle.
REQ-010 out_alu_ctrl  output  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9.
REQ-011 out_rs1, out_rs2, out_rd  output  5 each  register indices from instr[19:15], [24:20], [11:7].
REQ-012 out_imm  output  32  sign-extended immediate per format (I/S/B/U/J), 0 for R-type.
REQ-013 out_alu_src_imm  output  1  ALU operand B = out_imm (1) or rs2 (0).
REQ-014 out_reg_write  output  1  rd written; 0 when rd==0.
REQ-015 out_is_branch, out_is_jump, out_is_load, out_is_store  output  1 each  instruction class.
REQ-016 out_illegal  output  1  instruction not decodable.
REQ-017 out_pc  output  32  pc carried with bundle.

Function
REQ-018 Single registered stage: bundle appears on out_* the cycle after acceptance (latency 1).
REQ-019 Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-020 While out_valid & !out_ready, all out_* held stable.
REQ-021 OP (0110011): funct3/funct7 select ALU op; funct7=0100000 legal only with funct3 000 (SUB) or 101 (SRA); other funct7 != 0 -> illegal.
REQ-022 OP-IMM (0010011): alu_src_imm=1; funct3 001 requires funct7=0 (SLL); 101 with funct7 0 -> SRL, 0100000 -> SRA, else illegal; out_imm[4:0] = shamt for shifts.
REQ-023 BRANCH: BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU; funct3 010/011 illegal; reg_write=0.
REQ-024 LOAD, STORE, JALR, JAL, LUI, AUIPC -> ADD; STORE/BRANCH reg_write=0.
REQ-025 Any other opcode, or instr[1:0] != 11 -> illegal.
REQ-026 Illegal bundle: out_illegal=1, out_alu_ctrl=ADD, reg_write and all class flags 0, still transferred with handshake.
REQ-027 flush: out_valid cleared next cycle; instr presented the same cycle is dropped; flush dominates simultaneous in/out transfer.
REQ-028 Simultaneous out transfer and in transfer: new bundle replaces old with no bubble.

Reset
REQ-029 rst_n low: out_valid=0 immediately; all other out_* = 0; in_ready=1 after rst_n deasserts.
REQ-030 Reset mid-transfer discards held bundle; no partial output.

Configuration
REQ-031 Macro DECODER_SKID_EN defined: 2-entry skid buffer; in_ready is a register output, with no combinational path from out_ready; full throughput preserved.
REQ-032 DECODER_SKID_EN undefined: in_ready = !out_valid | out_ready (combinational); single output register.
REQ-033 Decode results and ordering identical in both configurations; flush empties both skid entries.

Verification
REQ-034 instr=0x40208033 -> alu_ctrl=1, rs1=1, rs2=2, rd=0, reg_write=0, alu_src_imm=0, illegal=0.
REQ-035 instr=0xFFF00093 -> alu_ctrl=0, imm=0xFFFFFFFF, rd=1, reg_write=1, alu_src_imm=1.
REQ-036 instr=0x40525193 -> alu_ctrl=7, imm=5, rs1=4, rd=3; instr=0x00000000 -> illegal=1, reg_write=0.
REQ-037 Stream of 4 instrs, out_ready low 3 cycles mid-stream -> outputs stable while stalled, order preserved, none lost or duplicated.
REQ-038 flush asserted with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, flushed instr never emitted.
REQ-039 rst_n pulsed low while out_valid=1 -> out_valid=0 same cycle, first instr after reset emitted correctly.

Source files
------------

// File: rtl/riscv_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_decoder
//  Purpose  : Single-stage registered RV32I instruction decoder with a
//             valid/ready handshake on both sides. Each accepted instr/pc
//             pair is decoded into ALU control, register indices, a
//             sign-extended immediate and class flags. The bundle appears
//             on out_* one cycle after acceptance.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   rising-edge clock
//    rst_n           in   1   asynchronous active-low reset
//    flush           in   1   drop held bundle(s) and the incoming instr
//    in_valid        in   1   instr/pc valid
//    in_ready        out  1   decoder can accept instr/pc
//    instr           in  32   RV32I instruction word
//    pc              in  32   address of instr
//    out_valid       out  1   decoded bundle valid
//    out_ready       in   1   downstream takes the bundle
//    out_alu_ctrl    out  4   ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
//    out_rs1/rs2/rd  out  5   register indices
//    out_imm         out 32   sign-extended immediate (0 for R-type)
//    out_alu_src_imm out  1   operand B is out_imm
//    out_reg_write   out  1   rd is written (never for rd == 0)
//    out_is_*        out  1   branch / jump / load / store class
//    out_illegal     out  1   instruction not decodable
//    out_pc          out 32   pc carried with the bundle
// ----------------------------------------------------------------------------
//  Configuration macro
//    DECODER_SKID_EN  defined : 2-entry skid buffer, in_ready is a flop
//                     undefined: single output register,
//                                in_ready = !out_valid | out_ready
// ============================================================================
module riscv_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_ctrl,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_alu_src_imm,
  output logic        out_reg_write,
  output logic        out_is_branch,
  output logic        out_is_jump,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Bundle: alu(4) rs1(5) rs2(5) rd(5) imm(32) flags(7) pc(32)
  localparam int BUNDLE_W = 90;

  // --------------------------------------------------------------------------
  // Field extraction and immediates
  // --------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_sh;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_rd     = instr[11:7];

  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
  assign w_imm_u  = {instr[31:12], 12'b0};
  assign w_imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
  // Shift-immediate forms carry only the shift amount.
  assign w_imm_sh = {27'b0, instr[24:20]};

  // funct3 -> ALU op for the register/immediate arithmetic groups (funct7 = 0)
  logic [3:0] w_alu_f3;
  always_comb begin
    w_alu_f3 = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_f3 = ALU_ADD;
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b011:  w_alu_f3 = ALU_SLTU;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      default: w_alu_f3 = ALU_AND;
    endcase
  end

  // --------------------------------------------------------------------------
  // Main decode
  // --------------------------------------------------------------------------
  logic [3:0]  w_alu;
  logic [31:0] w_imm;
  logic        w_src_imm;
  logic        w_wr_en;
  logic        w_is_branch;
  logic        w_is_jump;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_illegal;
  logic        w_reg_write;

  always_comb begin
    w_alu       = ALU_ADD;
    w_imm       = 32'b0;
    w_src_imm   = 1'b0;
    w_wr_en     = 1'b0;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_illegal   = 1'b0;

    // Full 7-bit opcode match also rejects instr[1:0] != 2'b11.
    case (w_opcode)
      OPC_OP: begin
        w_wr_en = 1'b1;
        if (w_funct7 == F7_ZERO) begin
          w_alu = w_alu_f3;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
          w_alu = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
          w_alu = ALU_SRA;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_wr_en   = 1'b1;
        w_src_imm = 1'b1;
        w_alu     = w_alu_f3;
        w_imm     = w_imm_i;
        if (w_funct3 == 3'b001) begin
          w_imm = w_imm_sh;
          if (w_funct7 != F7_ZERO) w_illegal = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          w_imm = w_imm_sh;
          if (w_funct7 == F7_ALT)        w_alu     = ALU_SRA;
          else if (w_funct7 != F7_ZERO)  w_illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        w_is_branch = 1'b1;
        w_imm       = w_imm_b;
        case (w_funct3)
          3'b000, 3'b001: w_alu     = ALU_SUB;
          3'b100, 3'b101: w_alu     = ALU_SLT;
          3'b110, 3'b111: w_alu     = ALU_SLTU;
          default:        w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_is_load = 1'b1;
        w_wr_en   = 1'b1;
        w_src_imm = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_STORE: begin
        w_is_store = 1'b1;
        w_src_imm  = 1'b1;
        w_imm      = w_imm_s;
      end
      OPC_JALR: begin
        w_is_jump = 1'b1;
        w_wr_en   = 1'b1;
        w_src_imm = 1'b1;
        w_imm     = w_imm_i;
      end
      OPC_JAL: begin
        w_is_jump = 1'b1;
        w_wr_en   = 1'b1;
        w_src_imm = 1'b1;
        w_imm     = w_imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_wr_en   = 1'b1;
        w_src_imm = 1'b1;
        w_imm     = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase

    // An illegal bundle carries no side effects, only the register fields/pc.
    if (w_illegal) begin
      w_alu       = ALU_ADD;
      w_imm       = 32'b0;
      w_src_imm   = 1'b0;
      w_wr_en     = 1'b0;
      w_is_branch = 1'b0;
      w_is_jump   = 1'b0;
      w_is_load   = 1'b0;
      w_is_store  = 1'b0;
    end
  end

  assign w_reg_write = w_wr_en & (w_rd != 5'd0);

  logic [BUNDLE_W-1:0] w_dec_bundle;
  assign w_dec_bundle = {w_alu, instr[19:15], instr[24:20], w_rd, w_imm,
                         w_src_imm, w_reg_write, w_is_branch, w_is_jump,
                         w_is_load, w_is_store, w_illegal, pc};

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic [BUNDLE_W-1:0] out_bundle_q;
  logic [BUNDLE_W-1:0] out_bundle_d;
  logic                out_valid_q;
  logic                out_valid_d;
  logic                w_accept;

`ifdef DECODER_SKID_EN
  // Second entry absorbs the instruction accepted in the cycle the output
  // stalls, so in_ready can come from a flop (empty skid entry).
  logic [BUNDLE_W-1:0] skid_bundle_q;
  logic [BUNDLE_W-1:0] skid_bundle_d;
  logic                skid_valid_q;
  logic                skid_valid_d;
  logic                in_ready_q;
  logic                w_out_free;

  assign w_accept   = in_valid & in_ready_q & ~flush;
  assign w_out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_bundle_d  = out_bundle_q;
    out_valid_d   = out_valid_q;
    skid_bundle_d = skid_bundle_q;
    skid_valid_d  = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (w_out_free) begin
        if (skid_valid_q) begin
          out_bundle_d = skid_bundle_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (w_accept) begin
          out_bundle_d = w_dec_bundle;
          out_valid_d  = 1'b1;
        end else begin
          out_valid_d  = 1'b0;
        end
      end
      // Accept is only possible with the skid entry empty.
      if (w_accept && !w_out_free) begin
        skid_bundle_d = w_dec_bundle;
        skid_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_bundle_q <= '0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      skid_bundle_q <= skid_bundle_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= ~skid_valid_d;
    end
  end

  assign in_ready = in_ready_q;
`else
  logic w_in_ready;

  assign w_in_ready = ~out_valid_q | out_ready;
  assign w_accept   = in_valid & w_in_ready & ~flush;

  always_comb begin
    out_bundle_d = out_bundle_q;
    out_valid_d  = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_bundle_d = w_dec_bundle;
      out_valid_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign in_ready = w_in_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bundle_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_bundle_q <= out_bundle_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {out_alu_ctrl, out_rs1, out_rs2, out_rd, out_imm, out_alu_src_imm,
          out_reg_write, out_is_branch, out_is_jump, out_is_load,
          out_is_store, out_illegal, out_pc} = out_bundle_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_decoder
//  Purpose  : Self-checking bench for riscv_decoder. A behavioural decode
//             model feeds an expected-bundle queue that is compared against
//             the DUT every cycle; directed literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_decoder;

  typedef struct packed {
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src;
    logic        rw;
    logic        br;
    logic        jmp;
    logic        ld;
    logic        st;
    logic        ill;
    logic [31:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = 32'b0;
  logic [31:0] pc = 32'b0;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  logic        out_alu_src_imm, out_reg_write, out_is_branch, out_is_jump;
  logic        out_is_load, out_is_store, out_illegal;

  riscv_decoder dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_alu_src_imm(out_alu_src_imm),
    .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_pop = 0;
  bundle_t     exp_q[$];
  logic        last_acc = 1'b0;
  logic        prev_stall = 1'b0;
  bundle_t     prev_b;
  logic [31:0] svec[$];

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] f3_op(input logic [2:0] f);
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    return tab[f];
  endfunction

  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] p);
    bundle_t b;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    b = '0;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd  = ins[11:7];
    b.pc  = p;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b1;
    case (ins[6:0])
      7'h33: begin
        b.rw = 1'b1;
        if (f7 == 7'h00) b.alu = f3_op(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) b.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) b.alu = 4'd7;
        else ok = 1'b0;
      end
      7'h13: begin
        b.rw = 1'b1; b.src = 1'b1;
        b.alu = f3_op(f3);
        b.imm = $signed(ins) >>> 20;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.imm = 32'(ins[24:20]);
          if (f3 == 3'd5 && f7 == 7'h20) b.alu = 4'd7;
          else if (f7 != 7'h00) ok = 1'b0;
        end
      end
      7'h63: begin
        b.br = 1'b1;
        b.imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19;
        if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
        else if (f3 < 3'd2) b.alu = 4'd1;
        else if (f3 < 3'd6) b.alu = 4'd3;
        else b.alu = 4'd4;
      end
      7'h03: begin b.ld = 1'b1; b.rw = 1'b1; b.src = 1'b1; b.imm = $signed(ins) >>> 20; end
      7'h23: begin
        b.st = 1'b1; b.src = 1'b1;
        b.imm = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20;
      end
      7'h67: begin b.jmp = 1'b1; b.rw = 1'b1; b.src = 1'b1; b.imm = $signed(ins) >>> 20; end
      7'h6F: begin
        b.jmp = 1'b1; b.rw = 1'b1; b.src = 1'b1;
        b.imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11;
      end
      7'h37, 7'h17: begin b.rw = 1'b1; b.src = 1'b1; b.imm = {ins[31:12], 12'b0}; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b.alu = 4'd0; b.imm = 32'd0; b.src = 1'b0; b.rw = 1'b0;
      b.br = 1'b0; b.jmp = 1'b0; b.ld = 1'b0; b.st = 1'b0;
      b.ill = 1'b1;
    end
    if (b.rd == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  function automatic bundle_t dut_b();
    return {out_alu_ctrl, out_rs1, out_rs2, out_rd, out_imm, out_alu_src_imm,
            out_reg_write, out_is_branch, out_is_jump, out_is_load,
            out_is_store, out_illegal, out_pc};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_b(input string nm, input bundle_t got, input bundle_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model; also advances the scoreboard for
  // the transfers that will happen at the coming rising edge.
  task automatic monitor();
    bundle_t cur;
    logic exp_rdy;
    cur = dut_b();
    last_acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk_b("rst_bundle", cur, '0);
      return;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
`ifdef DECODER_SKID_EN
    exp_rdy = exp_q.size() < 2;
`else
    exp_rdy = (exp_q.size() == 0) || out_ready;
`endif
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (prev_stall) chk_b("stall_hold", cur, prev_b);
    if (out_valid && exp_q.size() > 0) chk_b("bundle", cur, exp_q[0]);
    prev_stall = out_valid && !out_ready && !flush;
    prev_b = cur;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(instr, pc));
        last_acc = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] p);
    in_valid = 1'b1;
    instr = ins;
    pc = p;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("send_accept", {31'b0, last_acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  // Streams svec; out_ready low in [st_lo, st_lo+st_len) and, if toggle,
  // every fourth cycle.
  task automatic run_stream(input int st_lo, input int st_len, input bit toggle);
    int idx, c, pops0, n;
    idx = 0; c = 0; pops0 = n_pop; n = svec.size();
    while (c < 300 && (idx < n || exp_q.size() > 0)) begin
      out_ready = !((c >= st_lo && c < st_lo + st_len) || (toggle && (c % 4) == 3));
      in_valid  = idx < n;
      instr     = (idx < n) ? svec[idx] : 32'd0;
      pc        = 32'h1000 + 32'(idx * 4);
      tick();
      if (last_acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(n_pop - pops0), 32'(n));
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed literal vectors
    send(32'h40208033, 32'h100);
    chk("v0_valid", {31'b0, out_valid}, 32'd1);
    chk("v0_alu", {28'b0, out_alu_ctrl}, 32'd1);
    chk("v0_rs1", {27'b0, out_rs1}, 32'd1);
    chk("v0_rs2", {27'b0, out_rs2}, 32'd2);
    chk("v0_rd", {27'b0, out_rd}, 32'd0);
    chk("v0_rw", {31'b0, out_reg_write}, 32'd0);
    chk("v0_src", {31'b0, out_alu_src_imm}, 32'd0);
    chk("v0_ill", {31'b0, out_illegal}, 32'd0);
    chk("v0_pc", out_pc, 32'h100);

    send(32'hFFF00093, 32'h104);
    chk("v1_alu", {28'b0, out_alu_ctrl}, 32'd0);
    chk("v1_imm", out_imm, 32'hFFFFFFFF);
    chk("v1_rd", {27'b0, out_rd}, 32'd1);
    chk("v1_rw", {31'b0, out_reg_write}, 32'd1);
    chk("v1_src", {31'b0, out_alu_src_imm}, 32'd1);

    send(32'h40525193, 32'h108);
    chk("v2_alu", {28'b0, out_alu_ctrl}, 32'd7);
    chk("v2_imm", out_imm, 32'd5);
    chk("v2_rs1", {27'b0, out_rs1}, 32'd4);
    chk("v2_rd", {27'b0, out_rd}, 32'd3);

    send(32'h00000000, 32'h10C);
    chk("v3_ill", {31'b0, out_illegal}, 32'd1);
    chk("v3_rw", {31'b0, out_reg_write}, 32'd0);
    chk("v3_alu", {28'b0, out_alu_ctrl}, 32'd0);
    repeat (2) tick();

    // Mixed classes with a toggling out_ready
    svec = '{32'h002081B3, 32'h0020F233, 32'h02208033, 32'h00209463,
             32'h0020E463, 32'h0020A463, 32'h0040A283, 32'h0050A223,
             32'h008000EF, 32'h000080E7, 32'h123452B7, 32'h00001317,
             32'h00209093, 32'h02209093, 32'h0020D093, 32'h0000000F,
             32'hFFF0C093, 32'h00000030, 32'hFE000EE3};
    run_stream(100, 0, 1'b1);

    // Four instructions, out_ready low for three cycles mid-stream
    svec = '{32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213};
    run_stream(2, 3, 1'b0);

    // Flush with a held bundle and an incoming instruction
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200);
    in_valid = 1'b1;
    instr = 32'h0020F233;
    pc = 32'h204;
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Reset while a bundle is held
    out_ready = 1'b0;
    send(32'h0050A223, 32'h300);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_async_imm", out_imm, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(32'h123452B7, 32'h400);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_imm", out_imm, 32'h12345000);
    chk("post_rst_rd", {27'b0, out_rd}, 32'd5);
    chk("post_rst_rw", {31'b0, out_reg_write}, 32'd1);
    chk("post_rst_pc", out_pc, 32'h400);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
